bus_xfer_sequencer: RTL and testbench

- Drives the other end of the datapath bus. It takes a coded register-transfer request (source code, destination code) and decodes it into the one-hot source-drive enables the bus multiplexer consumes.
- It then sequences the matching one-hot destination-latch enable, so exactly one register drives the bus and exactly one register captures it.
- It sits between the control unit and the datapath, and replaces hand-raised Rout/Rin strobes.

---
 rtl/bus_xfer_sequencer.sv | 148 ++++++++++++++
 tb/tb_bus_xfer_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer
// Turns a coded register-transfer request (source code, destination code)
// into a one-hot bus-drive enable followed by a one-hot latch enable, so
// exactly one register drives the bus and exactly one register captures it.
// Every output comes straight from a flop, so req_* never reaches
// out_en/in_en combinationally.

module bus_xfer_sequencer #(
    parameter int NUM_SRC     = 24,  // R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, In_Port, C
    parameter int NUM_DST     = 25,  // R0-R15, HI, LO, Y, Z, PC, MDR, MAR, IR, Out_Port
    parameter int HOLD_CYCLES = 1    // cycles on the bus before the latch cycle (0-15)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               req_valid,
    input  logic [4:0]         req_src,
    input  logic [4:0]         req_dst,
    output logic               req_ready,
    output logic [NUM_SRC-1:0] out_en,
    output logic [NUM_DST-1:0] in_en,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_LATCH,
        ST_DONE,
        ST_ERR
    } state_t;

    // Codes are unsigned 5-bit values; compare in 6 bits so a limit of 32
    // would still be representable.
    localparam logic [5:0]         SRC_LIMIT = 6'(NUM_SRC);
    localparam logic [5:0]         DST_LIMIT = 6'(NUM_DST);
    localparam logic [3:0]         HOLD_LOAD = 4'(HOLD_CYCLES);
    localparam logic [NUM_SRC-1:0] SRC_ONE   = NUM_SRC'(1);
    localparam logic [NUM_DST-1:0] DST_ONE   = NUM_DST'(1);

    state_t             state_q;
    logic [4:0]         src_q;
    logic [4:0]         dst_q;
    logic [3:0]         cnt_q;
    logic               req_ready_q;
    logic [NUM_SRC-1:0] out_en_q;
    logic [NUM_DST-1:0] in_en_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic accept;
    logic codes_ok;

    // Handshake and range check on the raw request.
    assign accept   = req_valid && req_ready_q;
    assign codes_ok = ({1'b0, req_src} < SRC_LIMIT) && ({1'b0, req_dst} < DST_LIMIT);

    // Transfer sequencer: state, captured codes, hold counter and registered outputs.
    always_ff @(posedge clock) begin
        // NOTE: clear is synchronous and checked first, so it wins over any
        // request and wipes enables mid-transfer at the very next edge.
        if (clear) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            out_en_q    <= '0;
            in_en_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: every state register uses <= so all flops update from the
            // same pre-edge values regardless of statement order.
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        src_q       <= req_src;
                        dst_q       <= req_dst;
                        cnt_q       <= HOLD_LOAD;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (codes_ok) begin
                            out_en_q <= SRC_ONE << req_src;
                            if (HOLD_CYCLES > 0) begin
                                state_q <= ST_DRIVE;
                            end else begin
                                state_q <= ST_LATCH;
                                in_en_q <= DST_ONE << req_dst;
                            end
                        end else begin
                            // Rejected request: no enable is ever raised.
                            state_q <= ST_ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end

                ST_DRIVE: begin
                    // out_en holds its value; only the latch enable is added.
                    if (cnt_q <= 4'd1) begin
                        state_q <= ST_LATCH;
                        in_en_q <= DST_ONE << dst_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                ST_LATCH: begin
                    state_q  <= ST_DONE;
                    out_en_q <= '0;
                    in_en_q  <= '0;
                    done_q   <= 1'b1;
                end

                ST_DONE, ST_ERR: begin
                    state_q     <= ST_IDLE;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    out_en_q    <= '0;
                    in_en_q     <= '0;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign out_en    = out_en_q;
    assign in_en     = in_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer. Two instances (hold 1 and hold 3) share the
// same request inputs; each cycle's outputs are compared with a per-cycle
// trace derived from the transfer timeline.

module tb_bus_xfer_sequencer;

    localparam int NS = 24;
    localparam int ND = 25;

    logic       clock = 1'b0;
    logic       clear;
    logic       req_valid;
    logic [4:0] req_src;
    logic [4:0] req_dst;

    logic          ready_a, busy_a, done_a, err_a;
    logic [NS-1:0] out_en_a;
    logic [ND-1:0] in_en_a;
    logic          ready_b, busy_b, done_b, err_b;
    logic [NS-1:0] out_en_b;
    logic [ND-1:0] in_en_b;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [NS-1:0] oe;
        logic [ND-1:0] ie;
        logic          busy;
        logic          done;
        logic          err;
        logic          ready;
    } obs_t;

    always #5 clock = ~clock;

    bus_xfer_sequencer #(.NUM_SRC(NS), .NUM_DST(ND), .HOLD_CYCLES(1)) u_dut_h1 (
        .clock(clock), .clear(clear), .req_valid(req_valid),
        .req_src(req_src), .req_dst(req_dst), .req_ready(ready_a),
        .out_en(out_en_a), .in_en(in_en_a), .busy(busy_a),
        .done(done_a), .err(err_a)
    );

    bus_xfer_sequencer #(.NUM_SRC(NS), .NUM_DST(ND), .HOLD_CYCLES(3)) u_dut_h3 (
        .clock(clock), .clear(clear), .req_valid(req_valid),
        .req_src(req_src), .req_dst(req_dst), .req_ready(ready_b),
        .out_en(out_en_b), .in_en(in_en_b), .busy(busy_b),
        .done(done_b), .err(err_b)
    );

    // Expected outputs in cycle k after the accepting edge, for hold h.
    function automatic obs_t model(input int src, input int dst, input int h, input int k);
        obs_t e;
        e = '0;
        if (src >= NS || dst >= ND) begin
            if (k == 1) begin
                e.done = 1'b1;
                e.err  = 1'b1;
                e.busy = 1'b1;
            end else begin
                e.ready = 1'b1;
            end
        end else if (k <= h + 1) begin
            e.oe   = NS'(1) << src;
            e.busy = 1'b1;
            if (k == h + 1) e.ie = ND'(1) << dst;
        end else if (k == h + 2) begin
            e.done = 1'b1;
            e.busy = 1'b1;
        end else begin
            e.ready = 1'b1;
        end
        return e;
    endfunction

    function automatic obs_t idle_obs();
        obs_t e;
        e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    function automatic obs_t obs_a();
        return {out_en_a, in_en_a, busy_a, done_a, err_a, ready_a};
    endfunction

    function automatic obs_t obs_b();
        return {out_en_b, in_en_b, busy_b, done_b, err_b, ready_b};
    endfunction

    // One transfer through both instances; checks cycles 1..6 after acceptance.
    task automatic run_xfer(input string name, input int src, input int dst, input bit change);
        obs_t got [2];
        obs_t exp [2];
        int   hs  [2];
        hs[0] = 1;
        hs[1] = 3;
        @(negedge clock);
        req_valid = 1'b1;
        req_src   = src[4:0];
        req_dst   = dst[4:0];
        @(posedge clock);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            got[0] = obs_a();
            got[1] = obs_b();
            for (int d = 0; d < 2; d++) begin
                exp[d] = model(src, dst, hs[d], k);
                tests_run++;
                if (got[d] !== exp[d]) begin
                    tests_failed++;
                    $display("FAIL %s h=%0d src=%0d dst=%0d cycle=%0d: got oe=%h ie=%h busy=%b done=%b err=%b rdy=%b, want oe=%h ie=%h busy=%b done=%b err=%b rdy=%b",
                             name, hs[d], src, dst, k,
                             got[d].oe, got[d].ie, got[d].busy, got[d].done, got[d].err, got[d].ready,
                             exp[d].oe, exp[d].ie, exp[d].busy, exp[d].done, exp[d].err, exp[d].ready);
                end
            end
            if (k == 1) begin
                req_valid = 1'b0;
                if (change) begin
                    req_src = ~req_src;
                    req_dst = ~req_dst;
                end
            end
        end
    endtask

    task automatic test_reset();
        obs_t got;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        clear     = 1'b1;
        repeat (2) @(posedge clock);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            clear = 1'b0;
            got = obs_a();
            tests_run++;
            if (got !== idle_obs()) begin
                tests_failed++;
                $display("FAIL reset_h1 cycle=%0d: got %h want %h", c, got, idle_obs());
            end
            got = obs_b();
            tests_run++;
            if (got !== idle_obs()) begin
                tests_failed++;
                $display("FAIL reset_h3 cycle=%0d: got %h want %h", c, got, idle_obs());
            end
        end
    endtask

    task automatic test_basic();
        run_xfer("basic_pc_to_mar", 20, 22, 1'b0);
    endtask

    task automatic test_hold3();
        run_xfer("zlow_to_r5", 19, 5, 1'b0);
    endtask

    task automatic test_invalid();
        run_xfer("bad_src27", 27, 2, 1'b0);
        run_xfer("bad_dst30", 0, 30, 1'b0);
        run_xfer("bad_src24", 24, 0, 1'b0);
        run_xfer("bad_dst25", 0, 25, 1'b0);
        run_xfer("edge_23_24", 23, 24, 1'b0);
    endtask

    task automatic test_src_eq_dst();
        run_xfer("r3_to_r3", 3, 3, 1'b0);
    endtask

    task automatic test_change_ignored();
        run_xfer("change_ignored", 3, 7, 1'b1);
    endtask

    task automatic test_clear_mid();
        obs_t got;
        @(negedge clock);
        req_valid = 1'b1;
        req_src   = 5'd1;
        req_dst   = 5'd2;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        // h1 instance is in its LATCH cycle here.
        tests_run++;
        if (in_en_a !== ND'(1) << 2) begin
            tests_failed++;
            $display("FAIL clear_mid_latch: got in_en=%h want %h", in_en_a, ND'(1) << 2);
        end
        clear = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            clear = 1'b0;
            got = obs_a();
            tests_run++;
            if (got !== idle_obs()) begin
                tests_failed++;
                $display("FAIL clear_mid_h1 cycle=%0d: got %h want %h", c, got, idle_obs());
            end
            got = obs_b();
            tests_run++;
            if (got !== idle_obs()) begin
                tests_failed++;
                $display("FAIL clear_mid_h3 cycle=%0d: got %h want %h", c, got, idle_obs());
            end
        end
        run_xfer("after_clear_hi_to_r0", 16, 0, 1'b0);
    endtask

    task automatic test_random();
        int src;
        int dst;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                src = int'($urandom_range(0, NS - 1));
                dst = int'($urandom_range(0, ND - 1));
            end else begin
                src = int'($urandom_range(0, 31));
                dst = int'($urandom_range(0, 31));
            end
            run_xfer("random", src, dst, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        run_xfer("b2b_first", 21, 23, 1'b0);
        run_xfer("b2b_second", 22, 24, 1'b0);
    endtask

    initial begin
        clear     = 1'b0;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        test_reset();
        test_basic();
        test_hold3();
        test_invalid();
        test_src_eq_dst();
        test_change_ignored();
        test_clear_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
